irq_src_ctrl: RTL
=================

IRQ_SRC_CTRL -- requirements
Module: irq_src_ctrl

Interface
REQ-001 Parameter N_SRC, default 8, number of interrupt source lines (1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  stage enable; 0 freezes source sampling, pending-set logic and o_irq.
REQ-005 i_src  input  N_SRC  raw peripheral interrupt lines, active-high.
REQ-006 i_wr  input  1  register write strobe, single cycle.
REQ-007 i_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 MODE, 3 ACTIVE.
REQ-008 i_wdata  input  32  write data.
REQ-009 o_rdata  output  32  read data for i_addr, combinational from current register state; unused upper bits read 0.
REQ-010 o_irq  output  1  registered request to the core IRQ latch; high while any enabled pending bit exists.

Function
REQ-011 ENABLE[N_SRC-1:0] SHALL be read/write; a write at address 0 loads i_wdata[N_SRC-1:0].
REQ-012 MODE[N_SRC-1:0] SHALL be read/write; bit=1 selects rising-edge detect, bit=0 selects level detect.
REQ-013 PENDING[N_SRC-1:0] SHALL be readable; a write at address 1 clears each bit whose i_wdata bit is 1 (write-1-to-clear); 0 bits leave it unchanged.
REQ-014 A sampled-source register src_q SHALL hold the previous cycle's sampled source when en=1.
REQ-015 Edge mode: PENDING[i] SHALL set on the clock edge where sampled src[i]=1 and src_q[i]=0 and en=1.
REQ-016 Level mode: PENDING[i] SHALL set on every clock edge where sampled src[i]=1 and en=1.
REQ-017 Set SHALL win over a simultaneous W1C on the same bit in the same cycle.
REQ-018 PENDING SHALL set regardless of ENABLE; ENABLE masks only o_irq and ACTIVE.
REQ-019 o_irq SHALL register |(PENDING & ENABLE) one cycle after that term changes, when en=1; it holds its value when en=0.
REQ-020 ACTIVE (address 3, read-only) SHALL return bit 31 = |(PENDING & ENABLE) and bits[4:0] = index of the lowest-numbered enabled pending source (0 when none); writes are ignored.
REQ-021 Register writes SHALL take effect regardless of en.
REQ-022 Latency, no synchronizer: source rising at cycle n -> PENDING set at edge n+1 -> o_irq high at edge n+2.
REQ-023 Writes to MODE SHALL not clear PENDING; a level-to-edge switch with the source held high SHALL NOT generate a new set until the source falls and rises again.

Reset
REQ-024 On rst_n low, asynchronously: ENABLE=0, MODE=0, PENDING=0, src_q=0, synchronizer flops=0, o_irq=0.
REQ-025 Reset asserted mid-operation SHALL discard all pending requests; after release no set occurs for a source already high in edge mode until it falls and rises again, and o_irq stays 0 until the first set plus one cycle.

Configuration
REQ-026 Macro IRQ_SRC_SYNC_EN defined: each i_src bit SHALL pass through a two-flop synchronizer (clocked while en=1) before sampling, adding 2 cycles to REQ-022 latency.
REQ-027 Macro IRQ_SRC_SYNC_EN undefined: i_src SHALL be sampled directly; sources are then required to be synchronous to clk.

Verification
REQ-028 ENABLE=0x01, MODE=0x01, pulse i_src[0] for 1 cycle at cycle 10 -> PENDING=0x01 at 11, o_irq=1 at 12; write PENDING 0x01 -> o_irq=0 one cycle later.
REQ-029 MODE=0x00, ENABLE=0x04, hold i_src[2] high, write PENDING 0x04 -> PENDING reads 0x04 next cycle (set wins/re-sets); drop source then clear -> 0x00.
REQ-030 ENABLE=0x00, pulse i_src[5] -> PENDING=0x20, o_irq=0, ACTIVE=0x00000000; write ENABLE 0x20 -> o_irq=1 next cycle, ACTIVE=0x80000005.
REQ-031 Sources 3 and 6 pending and enabled -> ACTIVE=0x80000003; clear bit 3 -> ACTIVE=0x80000006.
REQ-032 en=0 while i_src[1] pulses -> PENDING unchanged, o_irq held; write ENABLE during en=0 -> readback reflects value.
REQ-033 Assert rst_n low with PENDING=0xFF, o_irq=1 -> all registers and o_irq 0 immediately; with IRQ_SRC_SYNC_EN, repeat REQ-028 -> o_irq at cycle 14.

Source files
------------

// File: rtl/irq_src_ctrl.sv
// Interrupt source controller: per-source edge/level detect, W1C pending, enable mask,
// lowest-index ACTIVE encoder and a registered o_irq. Define IRQ_SRC_SYNC_EN to add a
// two-flop input synchronizer per source (two extra cycles of detect latency).
module irq_src_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_SRC-1:0] i_src,
  input  logic             i_wr,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    ADDR_ENABLE  = 2'd0,
    ADDR_PENDING = 2'd1,
    ADDR_MODE    = 2'd2,
    ADDR_ACTIVE  = 2'd3
  } addr_e;

  addr_e            addr;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] src_s;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] masked;
  logic             any_act;
  logic [4:0]       act_idx;
  logic             irq_q;
  logic             wr_enable;
  logic             wr_pending;
  logic             wr_mode;
  logic             unused_wdata;

  assign addr         = addr_e'(i_addr);
  assign wr_enable    = i_wr && (addr == ADDR_ENABLE);
  assign wr_pending   = i_wr && (addr == ADDR_PENDING);
  assign wr_mode      = i_wr && (addr == ADDR_MODE);
  // Upper write-data bits are architecturally ignored when N_SRC < 32.
  assign unused_wdata = ^i_wdata;

`ifdef IRQ_SRC_SYNC_EN
  logic [N_SRC-1:0] sync1_q;
  logic [N_SRC-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (en) begin
      sync1_q <= i_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = i_src;
`endif

  // src_q tracks the sampled line in both modes, so switching level->edge while a
  // source is held high cannot fabricate an edge.
  assign set_vec   = en ? (src_s & (~mode_q | ~src_q)) : '0;
  assign clr_vec   = wr_pending ? i_wdata[N_SRC-1:0] : '0;
  assign pending_d = (pending_q & ~clr_vec) | set_vec;

  assign masked  = pending_q & enable_q;
  assign any_act = |masked;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    act_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) act_idx = 5'(i);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (addr)
      ADDR_ENABLE:  o_rdata = 32'(enable_q);
      ADDR_PENDING: o_rdata = 32'(pending_q);
      ADDR_MODE:    o_rdata = 32'(mode_q);
      ADDR_ACTIVE:  o_rdata = {any_act, 26'd0, act_idx};
      default:      o_rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_enable) enable_q <= i_wdata[N_SRC-1:0];
      if (wr_mode)   mode_q   <= i_wdata[N_SRC-1:0];
      pending_q <= pending_d;
      if (en) begin
        src_q <= src_s;
        irq_q <= any_act;
      end
    end
  end

  assign o_irq = irq_q;

endmodule
